bnn_load_sequencer: RTL and testbench

- Sequencer in front of the BNN network datapath.
- Accepts a byte stream: image bits, then layer-1 kernels, then layer-2 kernels. Packs each field into the flat buses the network consumes.
- Holds those buses stable for a fixed settle window, then captures the network's classification result.
- Sits between the tile's 8-bit input pins and the BNN_Network instance. It is the only writer of the network's operand buses.

---
 rtl/bnn_load_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_bnn_load_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bnn_load_sequencer.sv
// rtl/bnn_load_sequencer.sv - byte-stream loader and run sequencer for the BNN network
//
// Packs an 8-bit stream (image, then layer-1 kernels, then layer-2 kernels)
// into the flat operand buses of the network, holds them through a settle
// window, then captures the network class output.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_start            start a load/run pass (honoured in IDLE/DONE only)
//   in_data/in_valid     stream byte and its qualifier
//   in_ready             byte accepted when in_valid & in_ready
//   img_buff/k1_bus/k2_bus  operand buses to the network
//   net_result           network class output
//   busy                 high outside IDLE and DONE
//   result/result_valid  captured class of the last completed pass
module bnn_load_sequencer #(
  parameter int IMG_WIDTH    = 30,
  parameter int BNN1_CHANL   = 8,
  parameter int BNN2_CHANL   = 16,
  parameter int KERNEL_WIDTH = 3,
  parameter int RESULT_WIDTH = 4,
  parameter int RUN_CYCLES   = 4,
  localparam int IMG_SIZE    = IMG_WIDTH * IMG_WIDTH,
  localparam int KERNEL_SIZE = KERNEL_WIDTH * KERNEL_WIDTH,
  localparam int K1_BITS     = KERNEL_SIZE * BNN1_CHANL,
  localparam int K2_BITS     = KERNEL_SIZE * BNN1_CHANL * BNN2_CHANL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_start,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [IMG_SIZE-1:0]     img_buff,
  output logic [K1_BITS-1:0]      k1_bus,
  output logic [K2_BITS-1:0]      k2_bus,
  input  logic [RESULT_WIDTH-1:0] net_result,
  output logic                    busy,
  output logic [RESULT_WIDTH-1:0] result,
  output logic                    result_valid
);

  localparam int IMG_BYTES = (IMG_SIZE + 7) / 8;
  localparam int K1_BYTES  = (K1_BITS + 7) / 8;
  localparam int K2_BYTES  = (K2_BITS + 7) / 8;
  localparam int MAX_A     = (IMG_BYTES > K1_BYTES) ? IMG_BYTES : K1_BYTES;
  localparam int MAX_BYTES = (MAX_A > K2_BYTES) ? MAX_A : K2_BYTES;
  localparam int CNT_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int RUN_W     = $clog2(RUN_CYCLES + 1);

  localparam logic [CNT_W-1:0] IMG_LAST = CNT_W'(IMG_BYTES - 1);
  localparam logic [CNT_W-1:0] K1_LAST  = CNT_W'(K1_BYTES - 1);
  localparam logic [CNT_W-1:0] K2_LAST  = CNT_W'(K2_BYTES - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_CYCLES);

  localparam logic [IMG_SIZE-1:0] IMG_MASK = IMG_SIZE'(8'hFF);
  localparam logic [K1_BITS-1:0]  K1_MASK  = K1_BITS'(8'hFF);
  localparam logic [K2_BITS-1:0]  K2_MASK  = K2_BITS'(8'hFF);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_IMG = 3'd1,
    ST_LOAD_K1  = 3'd2,
    ST_LOAD_K2  = 3'd3,
    ST_RUN      = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
  logic [RUN_W-1:0]        run_cnt_q, run_cnt_d;
  logic [IMG_SIZE-1:0]     img_q, img_d;
  logic [K1_BITS-1:0]      k1_q, k1_d;
  logic [K2_BITS-1:0]      k2_q, k2_d;
  logic [RESULT_WIDTH-1:0] result_q, result_d;
  logic                    result_valid_q, result_valid_d;

  logic                    accept;
  logic [CNT_W+2:0]        bit_off;

  assign in_ready = (state_q == ST_LOAD_IMG) || (state_q == ST_LOAD_K1) ||
                    (state_q == ST_LOAD_K2);
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign accept   = in_valid && in_ready;
  // Bit position of the current byte within its field.
  assign bit_off  = {byte_cnt_q, 3'b000};

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    run_cnt_d      = run_cnt_q;
    img_d          = img_q;
    k1_d           = k1_q;
    k2_d           = k2_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;

    // Byte lanes are merged by shift-and-mask; anything shifted past the
    // top of a field falls off, which drops the unused bits of a last byte.
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cmd_start) begin
          state_d        = ST_LOAD_IMG;
          byte_cnt_d     = '0;
          run_cnt_d      = '0;
          result_valid_d = 1'b0;
        end
      end
      ST_LOAD_IMG: begin
        if (accept) begin
          img_d = (img_q & ~(IMG_MASK << bit_off)) | (IMG_SIZE'(in_data) << bit_off);
          if (byte_cnt_q == IMG_LAST) begin
            byte_cnt_d = '0;
            state_d    = ST_LOAD_K1;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_LOAD_K1: begin
        if (accept) begin
          k1_d = (k1_q & ~(K1_MASK << bit_off)) | (K1_BITS'(in_data) << bit_off);
          if (byte_cnt_q == K1_LAST) begin
            byte_cnt_d = '0;
            state_d    = ST_LOAD_K2;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_LOAD_K2: begin
        if (accept) begin
          k2_d = (k2_q & ~(K2_MASK << bit_off)) | (K2_BITS'(in_data) << bit_off);
          if (byte_cnt_q == K2_LAST) begin
            byte_cnt_d = '0;
            run_cnt_d  = '0;
            state_d    = ST_RUN;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RUN: begin
        // Counter runs 0..RUN_CYCLES so the capture edge lands RUN_CYCLES+1
        // edges after the final kernel byte was accepted.
        if (run_cnt_q == RUN_LAST) begin
          result_d       = net_result;
          result_valid_d = 1'b1;
          state_d        = ST_DONE;
        end else begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      byte_cnt_q     <= '0;
      run_cnt_q      <= '0;
      img_q          <= '0;
      k1_q           <= '0;
      k2_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      run_cnt_q      <= run_cnt_d;
      img_q          <= img_d;
      k1_q           <= k1_d;
      k2_q           <= k2_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign img_buff     = img_q;
  assign k1_bus       = k1_q;
  assign k2_bus       = k2_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_bnn_load_sequencer.sv
// tb/tb_bnn_load_sequencer.sv - scoreboard bench for bnn_load_sequencer
module tb_bnn_load_sequencer;

  localparam int IMG_SIZE  = 900;
  localparam int K1_BITS   = 72;
  localparam int K2_BITS   = 1152;
  localparam int IMG_BYTES = 113;
  localparam int K1_BYTES  = 9;
  localparam int TOTAL     = 266;
  localparam int LATENCY   = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cmd_start = 1'b0;
  logic [7:0]          in_data = 8'h00;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [IMG_SIZE-1:0] img_buff;
  logic [K1_BITS-1:0]  k1_bus;
  logic [K2_BITS-1:0]  k2_bus;
  logic [3:0]          net_result = 4'h0;
  logic                busy;
  logic [3:0]          result;
  logic                result_valid;

  bnn_load_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_start    (cmd_start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .img_buff     (img_buff),
    .k1_bus       (k1_bus),
    .k2_bus       (k2_bus),
    .net_result   (net_result),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]          res;
    logic [IMG_SIZE-1:0] img;
    logic [K1_BITS-1:0]  k1;
    logic [K2_BITS-1:0]  k2;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] stim[TOTAL];
  int         n_pass = 0;
  int         n_total = 0;
  int         edges = 0;
  int         last_acc_edge = 0;
  logic       rv_seen = 1'b0;

  always @(posedge clk) edges++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: field bit b is bit (b mod 8) of the field's byte (b div 8).
  function automatic exp_t model(input logic [3:0] res);
    exp_t e;
    e.res = res;
    for (int b = 0; b < IMG_SIZE; b++) e.img[b] = stim[b / 8][b % 8];
    for (int b = 0; b < K1_BITS; b++)  e.k1[b]  = stim[IMG_BYTES + b / 8][b % 8];
    for (int b = 0; b < K2_BITS; b++)  e.k2[b]  = stim[IMG_BYTES + K1_BYTES + b / 8][b % 8];
    return e;
  endfunction

  // Monitor: every rising result_valid retires one scoreboard entry.
  always @(negedge clk) begin
    if (result_valid && !rv_seen) begin
      if (sb.size() == 0) begin
        chk("unexpected_result_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("result", 32'(result), 32'(mon_e.res));
        chk("img_buff_match", 32'(img_buff === mon_e.img), 32'd1);
        chk("k1_bus_match", 32'(k1_bus === mon_e.k1), 32'd1);
        chk("k2_bus_match", 32'(k2_bus === mon_e.k2), 32'd1);
        chk("result_latency", 32'(edges - last_acc_edge), 32'(LATENCY));
      end
    end
    rv_seen = result_valid;
  end

  // mode: 0 gap-free, 1 alternate in_valid, 2 random in_valid.
  task automatic stream(input int mode, input int kick, input int limit);
    int idx = 0;
    int guard = 0;
    bit ph = 1'b0;
    while (idx < limit && guard < 3000) begin
      @(negedge clk);
      guard++;
      in_data = stim[idx];
      case (mode)
        0:       in_valid = 1'b1;
        1:       begin in_valid = ph; ph = !ph; end
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      cmd_start = (idx == kick);
      if (in_valid && in_ready) begin
        idx++;
        if (idx == TOTAL) last_acc_edge = edges + 1;
      end
    end
    if (idx < limit) chk("stream_timeout", 32'(idx), 32'(limit));
  endtask

  task automatic run_pass(input bit idx_pattern, input int mode, input int kick_k2,
                          input bit kick_run, input bit from_done);
    exp_t e;
    int   wait_n;
    for (int i = 0; i < TOTAL; i++) stim[i] = idx_pattern ? 8'(i) : 8'($urandom);
    net_result = idx_pattern ? 4'hA : 4'($urandom);
    e = model(net_result);
    sb.push_back(e);
    @(negedge clk);
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    if (from_done) begin
      chk("restart_result_valid", 32'(result_valid), 32'd0);
      chk("restart_in_ready", 32'(in_ready), 32'd1);
    end
    stream(mode, kick_k2, TOTAL);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    cmd_start = kick_run;
    chk("run_in_ready", 32'(in_ready), 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
    @(negedge clk);
    cmd_start = 1'b0;
    chk("run_busy_after_kick", 32'(busy), 32'd1);
    wait_n = 0;
    while (!result_valid && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    if (!result_valid) chk("result_valid_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_result_hold", 32'(result), 32'(e.res));
    chk("done_img_hold", 32'(img_buff === e.img), 32'd1);
    chk("done_k2_hold", 32'(k2_bus === e.k2), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #23;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_buses_zero", 32'((img_buff == '0) && (k1_bus == '0) && (k2_bus == '0)), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Index-pattern pass with the fixed values called out for the defaults.
    run_pass(1'b1, 0, -1, 1'b0, 1'b0);
    chk("img_byte0", 32'(img_buff[7:0]), 32'h00);
    chk("img_byte1", 32'(img_buff[15:8]), 32'h01);
    chk("img_last_nibble", 32'(img_buff[899:896]), 32'h0);
    chk("k1_byte0", 32'(k1_bus[7:0]), 32'h71);
    chk("k2_byte0", 32'(k2_bus[7:0]), 32'h7A);
    chk("result_A", 32'(result), 32'hA);

    // Restart from DONE, stalls every other cycle, cmd_start during K2 and RUN.
    run_pass(1'b0, 1, 200, 1'b1, 1'b1);
    chk("stall_k1_byte0", 32'(k1_bus[7:0]), 32'(stim[IMG_BYTES]));

    // Abort in LOAD_K1 after 5 kernel bytes.
    for (int i = 0; i < TOTAL; i++) stim[i] = 8'($urandom);
    @(negedge clk);
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    stream(0, -1, IMG_BYTES + 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result_valid", 32'(result_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_buses_zero", 32'((img_buff == '0) && (k1_bus == '0) && (k2_bus == '0)), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_pass(1'b1, 0, -1, 1'b0, 1'b0);
    run_pass(1'b0, 2, 150, 1'b1, 1'b1);
    run_pass(1'b0, 2, -1, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule
